modexp_pipe: RTL and testbench

Parametrised modular exponentiation engine computing `result = base^exponent mod modulus`. It processes the exponent right-to-left, one bit per step, with two serial modular multipliers running concurrently: one multiplies into the running product, the other squares. Operands are accepted on a valid/ready input handshake and results are returned on a valid/ready output handshake. It sits as the arithmetic core beneath the DSA/RSA signing and verification controllers.

---
 rtl/modexp_pkg.sv | 39 +++
 rtl/modexp_pipe_modmult.sv | 82 ++++++++
 rtl/modexp_pipe.sv | 155 +++++++++++++++
 tb/tb_modexp_pipe.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/modexp_pkg.sv
// Shared definitions for the modular exponentiation engine.
//   modexp_state_t : control FSM state encoding (also exported for debug).
//   clog2          : constant ceil(log2(v)), used to size step counters.
//   active_bits    : index of the highest set bit + 1 (0 for zero input);
//                    gives the number of exponent bits that actually need
//                    processing. Inputs are zero-extended to LEAD_ONE_MAX
//                    bits, which bounds the supported exponent width.
package modexp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_MSTART,
    S_MWAIT,
    S_UPDATE,
    S_DONE
  } modexp_state_t;

  localparam int LEAD_ONE_MAX = 256;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned active_bits(input logic [LEAD_ONE_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < LEAD_ONE_MAX; i++) begin
      if (v[i]) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/modexp_pipe_modmult.sv
// modmult_serial: serial modular multiplier, p = a*b mod m.
// Interleaved MSB-first shift-add over the bits of b: per bit r = 2r mod m,
// then r = (r + a) mod m when the bit is set. a, b < m is assumed, so the
// output is always fully reduced. The first bit is consumed on the start
// edge itself; the remaining WIDTH-1 bits take one cycle each, and done
// pulses for one cycle once p holds the final product.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (clears all state)
//   start       : one-cycle pulse latching a, b, m and beginning a product
//   a, b, m     : multiplicand, multiplier, modulus
//   p           : product (valid while done is high, held afterwards)
//   done        : one-cycle completion pulse
module modmult_serial
  import modexp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] p,
  output logic             done
);

  localparam int CW = clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_q, a_q, b_q, m_q;
  logic [CW-1:0]    cnt;
  logic             busy;

  // One shift-add step. The WIDTH+1 bit temporary absorbs 2r and r+a,
  // both of which stay below 2m.
  function automatic logic [WIDTH-1:0] mm_step(input logic [WIDTH-1:0] r,
                                               input logic [WIDTH-1:0] av,
                                               input logic             bit_i,
                                               input logic [WIDTH-1:0] mv);
    logic [WIDTH:0] t;
    t = {r, 1'b0};
    if (t >= {1'b0, mv}) t = t - {1'b0, mv};
    if (bit_i) begin
      t = t + {1'b0, av};
      if (t >= {1'b0, mv}) t = t - {1'b0, mv};
    end
    return t[WIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      m_q  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        r_q  <= mm_step('0, a, b[WIDTH-1], m);
        a_q  <= a;
        b_q  <= b << 1;
        m_q  <= m;
        cnt  <= CW'(WIDTH - 1);
        busy <= 1'b1;
      end else if (busy) begin
        r_q <= mm_step(r_q, a_q, b_q[WIDTH-1], m_q);
        b_q <= b_q << 1;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign p = r_q;

endmodule

// File: rtl/modexp_pipe.sv
// modexp_pipe: result = base^exponent mod modulus, right-to-left binary
// exponentiation with a product multiplier and a squarer running together.
// Build option: define MODEXP_CONST_TIME_EN to always process EXP_WIDTH
// exponent bits (data-independent latency); otherwise processing stops after
// the highest set exponent bit.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds its payload until that transfer.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   in_valid/in_ready          : operand handshake (base, exponent, modulus)
//   out_valid/out_ready        : result handshake (result, err)
//   err                        : modulus==0 or base>=modulus; result is 0
//   dbg_state                  : current control FSM state
module modexp_pipe
  import modexp_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 err,
  output modexp_state_t        dbg_state
);

  localparam int KW = clog2(EXP_WIDTH + 1);

  modexp_state_t        state, state_nxt;
  logic [WIDTH-1:0]     base_q, mod_q, acc, sq, result_q;
  logic [WIDTH-1:0]     prod, square, acc_init, acc_step;
  logic [EXP_WIDTH-1:0] exp_q, e;
  logic [KW-1:0]        k, k_init;
  logic                 err_q, out_valid_q, op_err, mult_start, done_p, done_s;

  assign op_err   = (mod_q == '0) || (base_q >= mod_q);
  // x^e mod 1 is 0 for every e, including e == 0.
  assign acc_init = (mod_q == WIDTH'(1)) ? '0 : WIDTH'(1);
  assign acc_step = e[0] ? prod : acc;

`ifdef MODEXP_CONST_TIME_EN
  assign k_init = KW'(EXP_WIDTH);
`else
  assign k_init = KW'(active_bits(LEAD_ONE_MAX'(exp_q)));
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (in_valid) state_nxt = S_SETUP;
      S_SETUP:  state_nxt = (op_err || k_init == '0) ? S_DONE : S_MSTART;
      S_MSTART: state_nxt = S_MWAIT;
      S_MWAIT:  if (done_p && done_s) state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = (k == KW'(1)) ? S_DONE : S_MSTART;
      S_DONE:   if (out_valid_q && out_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready   = (state == S_IDLE) && !reset;
    mult_start = (state == S_MSTART);
  end

  // Datapath. out_valid is registered off DONE so it rises the cycle after
  // DONE is entered and falls on the same edge as the output transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q      <= '0;
      exp_q       <= '0;
      mod_q       <= '0;
      acc         <= '0;
      sq          <= '0;
      e           <= '0;
      k           <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (state == S_DONE) && !(out_valid_q && out_ready);
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            base_q <= base;
            exp_q  <= exponent;
            mod_q  <= modulus;
          end
        end
        S_SETUP: begin
          err_q <= op_err;
          if (op_err) begin
            result_q <= '0;
          end else begin
            acc      <= acc_init;
            sq       <= base_q;
            e        <= exp_q;
            k        <= k_init;
            result_q <= acc_init;
          end
        end
        S_UPDATE: begin
          acc      <= acc_step;
          result_q <= acc_step;
          sq       <= square;
          e        <= e >> 1;
          k        <= k - KW'(1);
        end
        default: ;
      endcase
    end
  end

  modmult_serial #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (mult_start),
    .a     (acc),
    .b     (sq),
    .m     (mod_q),
    .p     (prod),
    .done  (done_p)
  );

  modmult_serial #(.WIDTH(WIDTH)) u_sqr (
    .clk   (clk),
    .reset (reset),
    .start (mult_start),
    .a     (sq),
    .b     (sq),
    .m     (mod_q),
    .p     (square),
    .done  (done_s)
  );

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign err       = err_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_modexp_pipe.sv
`timescale 1ns/1ps
module tb_modexp_pipe;
  import modexp_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- 8-bit DUT ----------------
  logic       in_valid8 = 1'b0, out_ready8 = 1'b0;
  logic       in_ready8, out_valid8, err8;
  logic [7:0] base8 = '0, exp8 = '0, mod8 = '0, result8;
  modexp_state_t st8;

  modexp_pipe #(.WIDTH(8), .EXP_WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .base(base8), .exponent(exp8), .modulus(mod8), .out_valid(out_valid8),
    .out_ready(out_ready8), .result(result8), .err(err8), .dbg_state(st8)
  );

  // ---------------- 32-bit DUT ----------------
  logic        in_valid32 = 1'b0, out_ready32 = 1'b0;
  logic        in_ready32, out_valid32, err32;
  logic [31:0] base32 = '0, exp32 = '0, mod32 = '0, result32;
  modexp_state_t st32;

  modexp_pipe #(.WIDTH(32), .EXP_WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid32), .in_ready(in_ready32),
    .base(base32), .exponent(exp32), .modulus(mod32), .out_valid(out_valid32),
    .out_ready(out_ready32), .result(result32), .err(err32), .dbg_state(st32)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [8:0] exp_q[$];   // {err, result} expected for the 8-bit DUT

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  // Naive repeated multiplication; no binary decomposition of the exponent.
  function automatic longint unsigned ref_pow(longint unsigned b, longint unsigned e,
                                              longint unsigned m);
    longint unsigned r;
    r = 1 % m;
    for (longint unsigned i = 0; i < e; i++) r = (r * b) % m;
    return r;
  endfunction

  function automatic int exp_latency(int wbits, int ewbits, longint unsigned b,
                                     longint unsigned e, longint unsigned m);
    int k;
    if (m == 0 || b >= m) return 2;
`ifdef MODEXP_CONST_TIME_EN
    k = ewbits;
`else
    k = 0;
    while (e != 0) begin
      k++;
      e = e >> 1;
    end
`endif
    return 2 + k * (wbits + 2);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_op8(input string name, input logic [7:0] b, input logic [7:0] e,
                         input logic [7:0] m, input int hold,
                         input logic [7:0] exp_res, input logic exp_err);
    int n, lat, want_lat;
    want_lat = exp_latency(8, 8, b, e, m);
    base8 = b; exp8 = e; mod8 = m; in_valid8 = 1'b1;
    n = 0;
    while (in_ready8 !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin
      check({name, " in_ready timeout"}, 0, 1);
      in_valid8 = 1'b0;
      return;
    end
    @(posedge clk); #1;              // input handshake edge
    in_valid8 = 1'b0;
    lat = 0;
    while (out_valid8 !== 1'b1 && lat < 2000) begin @(posedge clk); #1; lat++; end
    check({name, " latency"}, 64'(lat), 64'(want_lat));
    check({name, " result"}, 64'(result8), 64'(exp_res));
    check({name, " err"}, 64'(err8), 64'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({name, " hold out_valid"}, 64'(out_valid8), 1);
      check({name, " hold result"}, 64'(result8), 64'(exp_res));
      check({name, " hold err"}, 64'(err8), 64'(exp_err));
      check({name, " hold in_ready"}, 64'(in_ready8), 0);
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;              // output handshake edge
    out_ready8 = 1'b0;
    check({name, " out_valid drop"}, 64'(out_valid8), 0);
    check({name, " in_ready after accept"}, 64'(in_ready8), 1);
  endtask

  task automatic run_op32(input string name, input logic [31:0] b, input logic [31:0] e,
                          input logic [31:0] m, input logic [31:0] exp_res);
    int n, lat;
    base32 = b; exp32 = e; mod32 = m; in_valid32 = 1'b1;
    n = 0;
    while (in_ready32 !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    lat = 0;
    while (out_valid32 !== 1'b1 && lat < 4000) begin @(posedge clk); #1; lat++; end
    check({name, " latency"}, 64'(lat), 64'(exp_latency(32, 32, b, e, m)));
    check({name, " result"}, 64'(result32), 64'(exp_res));
    check({name, " err"}, 64'(err32), 0);
    out_ready32 = 1'b1;
    @(posedge clk); #1;
    out_ready32 = 1'b0;
    check({name, " out_valid drop"}, 64'(out_valid32), 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] b, e, m;
    int         hold;
    logic [7:0] res;
    logic       er;
  } vec_t;

  vec_t tbl[10];

  logic [7:0] rb[30], re[30], rm[30];

  initial begin
    logic [8:0] want;
    bit         seen;

    tbl[0] = '{b: 8'd3,   e: 8'd13,  m: 8'd7,   hold: 0, res: 8'd3,   er: 1'b0};
    tbl[1] = '{b: 8'd4,   e: 8'd0,   m: 8'd11,  hold: 0, res: 8'd1,   er: 1'b0};
    tbl[2] = '{b: 8'd0,   e: 8'd5,   m: 8'd1,   hold: 0, res: 8'd0,   er: 1'b0};
    tbl[3] = '{b: 8'd5,   e: 8'd3,   m: 8'd0,   hold: 0, res: 8'd0,   er: 1'b1};
    tbl[4] = '{b: 8'd9,   e: 8'd2,   m: 8'd7,   hold: 0, res: 8'd0,   er: 1'b1};
    tbl[5] = '{b: 8'd0,   e: 8'd0,   m: 8'd5,   hold: 0, res: 8'd1,   er: 1'b0};
    tbl[6] = '{b: 8'd2,   e: 8'd10,  m: 8'd255, hold: 0, res: 8'd4,   er: 1'b0};
    tbl[7] = '{b: 8'd254, e: 8'd2,   m: 8'd255, hold: 0, res: 8'd1,   er: 1'b0};
    tbl[8] = '{b: 8'd200, e: 8'd1,   m: 8'd201, hold: 0, res: 8'd200, er: 1'b0};
    tbl[9] = '{b: 8'd3,   e: 8'd13,  m: 8'd7,   hold: 5, res: 8'd3,   er: 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 64'(in_ready8), 0);
    check("reset out_valid", 64'(out_valid8), 0);
    check("reset result", 64'(result8), 0);
    check("reset err", 64'(err8), 0);
    reset = 1'b0;
    #1;
    check("in_ready after reset", 64'(in_ready8), 1);

    // Directed table
    for (int i = 0; i < 10; i++)
      run_op8($sformatf("tbl%0d", i), tbl[i].b, tbl[i].e, tbl[i].m, tbl[i].hold,
              tbl[i].res, tbl[i].er);

    // Randomized ops against the reference model
    for (int i = 0; i < 30; i++) begin
      rm[i] = 8'($urandom_range(1, 255));
      rb[i] = 8'($urandom_range(0, int'(rm[i]) - 1));
      re[i] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) rm[i] = 8'd0;
        else rb[i] = 8'($urandom_range(int'(rm[i]), 255));
      end
      if (rm[i] == 0 || rb[i] >= rm[i]) exp_q.push_back({1'b1, 8'd0});
      else exp_q.push_back({1'b0, 8'(ref_pow(rb[i], re[i], rm[i]))});
    end
    for (int i = 0; i < 30; i++) begin
      want = exp_q.pop_front();
      run_op8($sformatf("rnd%0d", i), rb[i], re[i], rm[i], 0, want[7:0], want[8]);
    end

    // Abort during MWAIT: step 1 multiply is in progress 5 cycles in
    base8 = 8'd3; exp8 = 8'd13; mod8 = 8'd7; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort in_ready during reset", 64'(in_ready8), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("abort in_ready after reset", 64'(in_ready8), 1);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (out_valid8 === 1'b1) seen = 1'b1;
    end
    check("abort no output", 64'(seen), 0);
    run_op8("after abort", 8'd6, 8'd7, 8'd13, 0, 8'(ref_pow(6, 7, 13)), 1'b0);

    // 32-bit: Fermat, 2^(p-1) mod p = 1; plus a small-exponent case
    run_op32("w32 fermat", 32'd2, 32'hFFFF_FFFA, 32'hFFFF_FFFB, 32'd1);
    run_op32("w32 small", 32'h1234_5678, 32'd5, 32'hFFFF_FFFB,
             32'(ref_pow(64'h1234_5678, 5, 64'hFFFF_FFFB)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global time bound
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
